stage_sequencer: RTL and testbench

Multi-cycle stage controller for the CPU datapath. It generates the `pipeline_stage` encoding consumed by the control-signal generation logic and steps one instruction through IF, ID, EX, MEM and WB. It holds MEM while a load, store or stack access waits on the memory handshake, and bounds that wait with a timeout. It also counts retired instructions.

---
 rtl/stage_sequencer_pkg.sv | 23 ++
 rtl/mem_wait_timer.sv | 22 ++
 rtl/stage_sequencer.sv | 80 ++++++++
 tb/tb_stage_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared stage encodings and opcode-group bit indices for the stage sequencer
// and the control-signal generator.
package stage_sequencer_pkg;

  localparam int STAGE_W_DEF = 3;

  typedef enum logic [STAGE_W_DEF-1:0] {
    STAGE_IF  = 3'd0,
    STAGE_ID  = 3'd1,
    STAGE_EX  = 3'd2,
    STAGE_MEM = 3'd3,
    STAGE_WB  = 3'd4
  } stage_e;

  localparam int GROUP_ALU    = 0;
  localparam int GROUP_LOAD   = 1;
  localparam int GROUP_STORE  = 2;
  localparam int GROUP_STACK  = 3;
  localparam int GROUP_BRANCH = 4;
  localparam int GROUP_JUMP   = 5;
  localparam int GROUP_COUNT  = 6;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive MEM cycles without mem_ready; flags the last allowed cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wait_cnt <= '0;
    else if (clear)    wait_cnt <= '0;
    else if (count_en) wait_cnt <= wait_cnt + 8'd1;
  end

  assign expired = (wait_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB stage controller with bounded memory wait.
// Optional build macro STAGE_SKIP_EN: non-memory instructions bypass MEM.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int STAGE_W     = 3,
  parameter int GROUP_W     = GROUP_COUNT,
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [GROUP_W-1:0] opcode_group,
  input  logic               mem_ready,
  input  logic               err_clr,
  output logic [STAGE_W-1:0] pipeline_stage,
  output logic               stall,
  output logic               instr_done,
  output logic               mem_error,
  output logic [RET_W-1:0]   retired
);

  stage_e state, next_state;
  logic   mem_instr, in_mem, expired, timeout;
  logic   unused_grp;

  assign unused_grp = ^opcode_group;
  assign mem_instr  = opcode_group[GROUP_LOAD] | opcode_group[GROUP_STORE] |
                      opcode_group[GROUP_STACK];
  assign in_mem     = (state == STAGE_MEM);
  assign timeout    = in_mem && mem_instr && !mem_ready && expired;

  // Counter resets whenever we are outside MEM, so every access starts at zero.
  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!in_mem),
    .count_en (in_mem && mem_instr && !mem_ready),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= STAGE_IF;
    else        state <= next_state;
  end

  always_comb begin
    next_state = STAGE_IF;
    case (state)
      STAGE_IF:  next_state = run ? STAGE_ID : STAGE_IF;
      STAGE_ID:  next_state = STAGE_EX;
`ifdef STAGE_SKIP_EN
      STAGE_EX:  next_state = mem_instr ? STAGE_MEM : STAGE_WB;
`else
      STAGE_EX:  next_state = STAGE_MEM;
`endif
      STAGE_MEM: next_state = (!mem_instr || mem_ready || timeout) ? STAGE_WB : STAGE_MEM;
      STAGE_WB:  next_state = STAGE_IF;
      default:   next_state = STAGE_IF;
    endcase
  end

  assign pipeline_stage = STAGE_W'(state);
  assign stall          = in_mem && mem_instr && !mem_ready && !timeout;
  assign instr_done     = (state == STAGE_WB);

  // A timeout in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mem_error <= 1'b0;
    else if (timeout) mem_error <= 1'b1;
    else if (err_clr) mem_error <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retired <= '0;
    else if (instr_done) retired <= retired + 1'b1;
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized self-checking bench for stage_sequencer against an instruction-level model.
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

  localparam int RET_W = 4;
  localparam int TMO   = 15;
  localparam int GW    = GROUP_COUNT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             run = 1'b0;
  logic             mem_ready = 1'b0;
  logic             err_clr = 1'b0;
  logic [GW-1:0]    opcode_group = '0;
  logic [2:0]       pipeline_stage;
  logic             stall, instr_done, mem_error;
  logic [RET_W-1:0] retired;

  int               checks = 0;
  int               failures = 0;
  logic [RET_W-1:0] m_ret = '0;
  bit               m_err = 1'b0;
  bit               rand_clr = 1'b0;

  stage_sequencer #(.STAGE_W(3), .GROUP_W(GW), .MEM_TIMEOUT(TMO), .RET_W(RET_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode_group(opcode_group),
    .mem_ready(mem_ready), .err_clr(err_clr), .pipeline_stage(pipeline_stage),
    .stall(stall), .instr_done(instr_done), .mem_error(mem_error), .retired(retired)
  );

  always #5 clk = ~clk;

  // One instruction from its IF cycle back to the next IF. Entry/exit: 1 time unit after an edge.
  // delay = number of low mem_ready cycles presented in MEM before ready rises.
  task automatic do_instr(input int gidx, input int delay);
    logic [GW-1:0] g;
    bit            is_mem, tmo, exp_stall;
    int            k, p;
    stage_e        q[$];
    g = '0;
    g[gidx] = 1'b1;
    is_mem = (gidx == GROUP_LOAD) || (gidx == GROUP_STORE) || (gidx == GROUP_STACK);
    k   = is_mem ? ((delay + 1 < TMO) ? delay + 1 : TMO) : 1;
    tmo = is_mem && (delay >= TMO);
    q.push_back(STAGE_ID);
    q.push_back(STAGE_EX);
`ifdef STAGE_SKIP_EN
    if (is_mem) for (int i = 0; i < k; i++) q.push_back(STAGE_MEM);
`else
    for (int i = 0; i < k; i++) q.push_back(STAGE_MEM);
`endif
    q.push_back(STAGE_WB);

    opcode_group = g;
    run          = 1'b1;
    mem_ready    = 1'($urandom);
    err_clr      = rand_clr && ($urandom_range(0, 3) == 0);
    #1;
    checks++;
    if (pipeline_stage !== STAGE_IF) begin
      failures++; $display("FAIL if_stage: got %0d want %0d", pipeline_stage, STAGE_IF);
    end
    checks++;
    if (retired !== m_ret) begin
      failures++; $display("FAIL retired_in_if: got %0d want %0d", retired, m_ret);
    end
    checks++;
    if (mem_error !== m_err || stall !== 1'b0 || instr_done !== 1'b0) begin
      failures++; $display("FAIL if_flags: err/stall/done got %b%b%b want %b00",
                           mem_error, stall, instr_done, m_err);
    end
    if (err_clr) m_err = 1'b0;
    @(posedge clk); #1;

    p = 0;
    foreach (q[j]) begin
      run       = 1'($urandom);
      err_clr   = rand_clr && ($urandom_range(0, 3) == 0);
      mem_ready = (q[j] == STAGE_MEM && is_mem) ? (p >= delay) : 1'($urandom);
      #1;
      exp_stall = (q[j] == STAGE_MEM) && is_mem && (p < k - 1);
      checks++;
      if (pipeline_stage !== q[j]) begin
        failures++; $display("FAIL stage[%0d] grp=%0d: got %0d want %0d", j, gidx, pipeline_stage, q[j]);
      end
      checks++;
      if (stall !== exp_stall) begin
        failures++; $display("FAIL stall[%0d] grp=%0d: got %b want %b", j, gidx, stall, exp_stall);
      end
      checks++;
      if (instr_done !== (q[j] == STAGE_WB)) begin
        failures++; $display("FAIL instr_done[%0d]: got %b want %b", j, instr_done, q[j] == STAGE_WB);
      end
      checks++;
      if (mem_error !== m_err) begin
        failures++; $display("FAIL mem_error[%0d]: got %b want %b", j, mem_error, m_err);
      end
      if (q[j] == STAGE_MEM && p == k - 1 && tmo) m_err = 1'b1;
      else if (err_clr)                           m_err = 1'b0;
      if (q[j] == STAGE_WB)  m_ret = m_ret + 1'b1;
      if (q[j] == STAGE_MEM) p++;
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pipeline_stage !== STAGE_IF || stall !== 1'b0 || instr_done !== 1'b0 ||
        mem_error !== 1'b0 || retired !== '0) begin
      failures++; $display("FAIL reset_values: stage=%0d stall=%b done=%b err=%b ret=%0d want 0 0 0 0 0",
                           pipeline_stage, stall, instr_done, mem_error, retired);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pipeline_stage !== STAGE_IF) begin
      failures++; $display("FAIL idle_after_reset: got %0d want %0d", pipeline_stage, STAGE_IF);
    end
  endtask

  task automatic test_idle(input int n);
    for (int i = 0; i < n; i++) begin
      run       = 1'b0;
      mem_ready = 1'($urandom);
      #1;
      checks++;
      if (pipeline_stage !== STAGE_IF || retired !== m_ret) begin
        failures++; $display("FAIL idle_hold: stage=%0d ret=%0d want %0d %0d",
                             pipeline_stage, retired, STAGE_IF, m_ret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_timeout();
    do_instr(GROUP_STORE, 40);
    run     = 1'b0;
    err_clr = 1'b1;
    #1;
    checks++;
    if (mem_error !== 1'b1) begin
      failures++; $display("FAIL timeout_sets_error: got %b want 1", mem_error);
    end
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err   = 1'b0;
    #1;
    checks++;
    if (mem_error !== 1'b0) begin
      failures++; $display("FAIL err_clr: got %b want 0", mem_error);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int n);
    rand_clr = 1'b1;
    for (int i = 0; i < n; i++)
      do_instr($urandom_range(0, GW - 1), $urandom_range(0, 20));
    rand_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    opcode_group = '0;
    opcode_group[GROUP_STORE] = 1'b1;
    run       = 1'b1;
    mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (pipeline_stage !== STAGE_MEM || stall !== 1'b1) begin
      failures++; $display("FAIL pre_reset_mem: stage=%0d stall=%b want %0d 1", pipeline_stage, stall, STAGE_MEM);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pipeline_stage !== STAGE_IF || stall !== 1'b0 || instr_done !== 1'b0 ||
        mem_error !== 1'b0 || retired !== '0) begin
      failures++; $display("FAIL async_reset_mid: stage=%0d stall=%b done=%b err=%b ret=%0d want 0 0 0 0 0",
                           pipeline_stage, stall, instr_done, mem_error, retired);
    end
    m_ret = '0;
    m_err = 1'b0;
    @(posedge clk);
    @(negedge clk) begin rst_n = 1'b1; run = 1'b0; end
    @(posedge clk); #1;
    checks++;
    if (pipeline_stage !== STAGE_IF) begin
      failures++; $display("FAIL release_in_if: got %0d want %0d", pipeline_stage, STAGE_IF);
    end
  endtask

  initial begin
    test_reset();
    do_instr(GROUP_ALU, 0);
    do_instr(GROUP_LOAD, 3);
    test_store_timeout();
    do_instr(GROUP_STACK, 14);
    do_instr(GROUP_BRANCH, 5);
    test_idle(5);
    test_random(40);
    test_idle(3);
    test_reset_mid();
    do_instr(GROUP_JUMP, 0);
    do_instr(GROUP_LOAD, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
